// File: rtl/alu_arbiter_pkg.sv
// Shared ALU constants and arbiter types. The data width and op codes are
// kept as text macros so legacy code can keep using them; the package
// mirrors them as typed localparams for the RTL and bench.
`ifndef ALU_DEFINES_SV
`define ALU_DEFINES_SV
`define DATA_WIDTH   32
`define OP_ALU_ADD   6'd0
`define OP_ALU_SUB   6'd1
`define OP_ALU_AND   6'd2
`define OP_ALU_OR    6'd3
`define OP_ALU_XOR   6'd4
`define OP_ALU_SLL   6'd5
`define OP_ALU_SRL   6'd6
`define OP_ALU_SRA   6'd7
`define OP_ALU_SLT   6'd8
`define OP_ALU_SLTU  6'd9
`endif

package alu_arbiter_pkg;

   localparam int DATA_W  = `DATA_WIDTH;
   localparam int OP_W    = 6;
   localparam int SHAMT_W = $clog2(`DATA_WIDTH);

   localparam logic [OP_W-1:0] OP_ALU_ADD  = `OP_ALU_ADD;
   localparam logic [OP_W-1:0] OP_ALU_SUB  = `OP_ALU_SUB;
   localparam logic [OP_W-1:0] OP_ALU_AND  = `OP_ALU_AND;
   localparam logic [OP_W-1:0] OP_ALU_OR   = `OP_ALU_OR;
   localparam logic [OP_W-1:0] OP_ALU_XOR  = `OP_ALU_XOR;
   localparam logic [OP_W-1:0] OP_ALU_SLL  = `OP_ALU_SLL;
   localparam logic [OP_W-1:0] OP_ALU_SRL  = `OP_ALU_SRL;
   localparam logic [OP_W-1:0] OP_ALU_SRA  = `OP_ALU_SRA;
   localparam logic [OP_W-1:0] OP_ALU_SLT  = `OP_ALU_SLT;
   localparam logic [OP_W-1:0] OP_ALU_SLTU = `OP_ALU_SLTU;

   // Result slot plus round-robin pointer; owner is one-hot (bit k = requester k).
   typedef struct packed {
      logic              full;
      logic [1:0]        owner;
      logic [DATA_W-1:0] data;
      logic              pri;
   } arb_state_t;

   // Round-robin pick among two requesters: a lone requester always wins,
   // a tie goes to the requester named by pri.
   function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic pri);
      logic [1:0] pick;
      pick = 2'b00;
      case (valid)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = pri ? 2'b10 : 2'b01;
         default: pick = 2'b00;
      endcase
      return pick;
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters. Op codes outside the defined
// set produce zero.
module alu
   import alu_arbiter_pkg::*;
(
   input  logic [OP_W-1:0]   i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic [DATA_W-1:0] o_c
);

   logic [SHAMT_W-1:0] shamt;
   logic               lt_s;
   logic               lt_u;

   assign shamt = i_b[SHAMT_W-1:0];
   assign lt_s  = $signed(i_a) < $signed(i_b);
   assign lt_u  = i_a < i_b;

   // op decode
   always_comb begin
      o_c = '0;
      case (i_op)
         OP_ALU_ADD:  o_c = i_a + i_b;
         OP_ALU_SUB:  o_c = i_a - i_b;
         OP_ALU_AND:  o_c = i_a & i_b;
         OP_ALU_OR:   o_c = i_a | i_b;
         OP_ALU_XOR:  o_c = i_a ^ i_b;
         OP_ALU_SLL:  o_c = i_a << shamt;
         OP_ALU_SRL:  o_c = i_a >> shamt;
         OP_ALU_SRA:  o_c = $signed(i_a) >>> shamt;
         OP_ALU_SLT:  o_c = {{(DATA_W-1){1'b0}}, lt_s};
         OP_ALU_SLTU: o_c = {{(DATA_W-1){1'b0}}, lt_u};
         default:     o_c = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU with a
// one-deep registered result slot.
//
//   state | meaning
//   EMPTY | no result held; a valid request is granted this cycle
//   FULL  | result held for owner; a new grant only when owner consumes
//
// The slot refills on the same edge it is consumed, so a requester that
// keeps its response ready sees one result per cycle.
module alu_arbiter
   import alu_arbiter_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1:0]        i_req_valid,
   output logic [1:0]        o_req_ready,
   input  logic [OP_W-1:0]   i_req0_op,
   input  logic [DATA_W-1:0] i_req0_a,
   input  logic [DATA_W-1:0] i_req0_b,
   input  logic [OP_W-1:0]   i_req1_op,
   input  logic [DATA_W-1:0] i_req1_a,
   input  logic [DATA_W-1:0] i_req1_b,
   output logic [1:0]        o_rsp_valid,
   input  logic [1:0]        i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_c,
   input  logic              i_flush
);

   arb_state_t        arb_q;
   arb_state_t        arb_d;
   logic              consume;
   logic              slot_free;
   logic [1:0]        grant;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_c;

   // Only the owner's ready can drain the slot; the other bit is ignored.
   assign consume   = arb_q.full && |(arb_q.owner & i_rsp_ready);
   assign slot_free = !arb_q.full || consume;

   // Grant is held off during reset and flush so no operand is lost.
   always_comb begin
      grant = 2'b00;
      if (i_rst_n && !i_flush && slot_free) begin
         grant = rr_pick(i_req_valid, arb_q.pri);
      end
   end

   assign o_req_ready = grant;

   // Steer the winning requester's operands into the ALU.
   always_comb begin
      alu_op = i_req0_op;
      alu_a  = i_req0_a;
      alu_b  = i_req0_b;
      if (grant[1]) begin
         alu_op = i_req1_op;
         alu_a  = i_req1_a;
         alu_b  = i_req1_b;
      end
   end

   alu u_alu (
      .i_op (alu_op),
      .i_a  (alu_a),
      .i_b  (alu_b),
      .o_c  (alu_c)
   );

   // Slot and pointer update: flush beats grant, grant beats plain consume.
   // Data and owner are left alone when the slot empties.
   always_comb begin
      arb_d = arb_q;
      if (i_flush) begin
         arb_d.full = 1'b0;
      end else if (|grant) begin
         arb_d.full  = 1'b1;
         arb_d.owner = grant;
         arb_d.data  = alu_c;
         arb_d.pri   = grant[0];
      end else if (consume) begin
         arb_d.full = 1'b0;
      end
   end

   // All arbiter state in one register bank.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         arb_q <= '0;
      end else begin
         arb_q <= arb_d;
      end
   end

   assign o_rsp_valid = arb_q.full ? arb_q.owner : 2'b00;
   assign o_rsp_c     = arb_q.data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a result-slot model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [OP_W-1:0]   op0, op1;
   logic [DATA_W-1:0] a0, b0, a1, b1;
   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready;
   logic [DATA_W-1:0] rsp_c;
   logic              flush;

   int checks = 0;
   int errors = 0;

   // model: what the held result is, who owns it, whose turn it is
   bit                m_full;
   int                m_owner;
   logic [DATA_W-1:0] m_data;
   int                m_pri;
   int                m_grant;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req0_op   (op0),
      .i_req0_a    (a0),
      .i_req0_b    (b0),
      .i_req1_op   (op1),
      .i_req1_a    (a1),
      .i_req1_b    (b1),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_c     (rsp_c),
      .i_flush     (flush)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] alu_ref(input logic [OP_W-1:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      int unsigned sh;
      longint      sa;
      sh = b % 32;
      sa = longint'($signed(a));
      if (op == OP_ALU_ADD)  return a + b;
      if (op == OP_ALU_SUB)  return a - b;
      if (op == OP_ALU_AND)  return a & b;
      if (op == OP_ALU_OR)   return a | b;
      if (op == OP_ALU_XOR)  return a ^ b;
      if (op == OP_ALU_SLL)  return a << sh;
      if (op == OP_ALU_SRL)  return a >> sh;
      if (op == OP_ALU_SRA)  return DATA_W'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
      if (op == OP_ALU_SLT)  return ($signed(a) < $signed(b)) ? 1 : 0;
      if (op == OP_ALU_SLTU) return (a < b) ? 1 : 0;
      return '0;
   endfunction

   // Which requester the rules say wins now (-1 = nobody).
   function automatic int model_grant();
      bit free;
      if (!rst_n || flush) return -1;
      free = !m_full || rsp_ready[m_owner];
      if (!free) return -1;
      if (req_valid == 2'b11) return m_pri;
      if (req_valid == 2'b01) return 0;
      if (req_valid == 2'b10) return 1;
      return -1;
   endfunction

   function automatic logic [1:0] onehot(input int k);
      if (k < 0) return 2'b00;
      return (k == 0) ? 2'b01 : 2'b10;
   endfunction

   task automatic model_step();
      if (flush) begin
         m_full = 0;
      end else if (m_grant >= 0) begin
         m_full  = 1;
         m_owner = m_grant;
         m_data  = (m_grant == 1) ? alu_ref(op1, a1, b1) : alu_ref(op0, a0, b0);
         m_pri   = 1 - m_grant;
      end else if (m_full && rsp_ready[m_owner]) begin
         m_full = 0;
      end
   endtask

   // One clock: compare at the falling edge, advance the model on the rising
   // edge, return 1 time unit later.
   task automatic cycle();
      @(negedge clk);
      m_grant = model_grant();
      chk("req_ready", {30'd0, req_ready}, {30'd0, onehot(m_grant)});
      chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, m_full ? onehot(m_owner) : 2'b00});
      if (m_full) chk("rsp_c", rsp_c, m_data);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 2'b00;
      flush     = 1'b0;
      rsp_ready = 2'b11;
   endtask

   task automatic do_reset();
      req_valid = 2'b11;
      rst_n     = 1'b0;
      #1;
      chk("rst_rsp_valid", {30'd0, rsp_valid}, 0);
      chk("rst_rsp_c", rsp_c, 0);
      chk("rst_req_ready", {30'd0, req_ready}, 0);
      m_full  = 0;
      m_owner = 0;
      m_pri   = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      idle_inputs();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      idle_inputs();
      m_data = '0;
      do_reset();

      // single ADD from requester 0
      op0 = OP_ALU_ADD; a0 = 32'd1; b0 = 32'd1;
      req_valid = 2'b01;
      cycle();
      chk("add_rsp_valid", {30'd0, rsp_valid}, 32'h1);
      chk("add_rsp_c", rsp_c, 32'h0000_0002);
      idle_inputs();
      cycle();

      // both requesting after reset: r0 first, then r1
      do_reset();
      op0 = OP_ALU_SUB; a0 = 32'd1;     b0 = 32'd1;
      op1 = OP_ALU_OR;  a1 = 32'h101;   b1 = 32'h10001;
      req_valid = 2'b11;
      cycle();
      chk("rr_first_owner", {30'd0, rsp_valid}, 32'h1);
      chk("rr_first_c", rsp_c, 32'h0000_0000);
      cycle();
      chk("rr_second_owner", {30'd0, rsp_valid}, 32'h2);
      chk("rr_second_c", rsp_c, 32'h0001_0101);
      idle_inputs();
      cycle();

      // held SRA result under backpressure
      op1 = OP_ALU_SRA; a1 = 32'h8000_0000; b1 = 32'h1f;
      req_valid = 2'b10;
      rsp_ready = 2'b00;
      cycle();
      chk("sra_rsp_valid", {30'd0, rsp_valid}, 32'h2);
      chk("sra_rsp_c", rsp_c, 32'hffff_ffff);
      op0 = OP_ALU_ADD; a0 = 32'd5; b0 = 32'd7;
      req_valid = 2'b11;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("hold_rsp_valid", {30'd0, rsp_valid}, 32'h2);
         chk("hold_rsp_c", rsp_c, 32'hffff_ffff);
         chk("hold_req_ready", {30'd0, req_ready}, 32'h0);
      end

      // flush beats the owner's consume; pointer stays on r0
      flush     = 1'b1;
      rsp_ready = 2'b10;
      cycle();
      chk("flush_rsp_valid", {30'd0, rsp_valid}, 32'h0);
      flush     = 1'b0;
      rsp_ready = 2'b11;
      #1;
      chk("flush_pri_kept", {30'd0, req_ready}, 32'h1);
      cycle();
      chk("post_flush_c", rsp_c, 32'd12);

      // r0 XOR stream, one result per cycle
      op0 = OP_ALU_XOR;
      req_valid = 2'b01;
      for (int i = 0; i < 6; i++) begin
         a0 = $urandom;
         b0 = $urandom;
         cycle();
         chk("stream_rsp_valid", {30'd0, rsp_valid}, 32'h1);
         chk("stream_rsp_c", rsp_c, a0 ^ b0);
      end
      req_valid = 2'b11;
      #1;
      chk("alt_pick_r1", {30'd0, req_ready}, 32'h2);
      cycle();
      #1;
      chk("alt_pick_r0", {30'd0, req_ready}, 32'h1);
      cycle();

      // reset while holding an SLL result
      op0 = OP_ALU_SLL; a0 = 32'd1; b0 = 32'h10;
      req_valid = 2'b01;
      cycle();
      chk("sll_rsp_c", rsp_c, 32'h0001_0000);
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      cycle();
      chk("sll_held", {30'd0, rsp_valid}, 32'h1);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("no_stale_rsp", {30'd0, rsp_valid}, 32'h0);
      end

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         req_valid = 2'($urandom);
         rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
         flush     = ($urandom_range(0, 15) == 0);
         op0 = ($urandom_range(0, 9) == 0) ? OP_W'($urandom) : OP_W'($urandom_range(0, 9));
         op1 = ($urandom_range(0, 9) == 0) ? OP_W'($urandom) : OP_W'($urandom_range(0, 9));
         a0 = $urandom;
         a1 = $urandom;
         b0 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
         b1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
